jtag_dmi_ctrl: RTL and testbench
================================

// Module: jtag_dmi_ctrl
// PURPOSE
//  Debug Transport controller behind the JTAG TAP; owns the DTMCS (IR 0x10) and DMI (IR 0x11) data registers.
//  Uses the TAP's ir/dr_capture/dr_shift/dr_update strobes and returns the DR serial bit on dr_tdo.
//  Sequences DMI read/write requests to the Debug Module over a valid/ready request/response pair.
//  Runs entirely in the TCLK domain; any CDC to the core clock lives in the Debug Module wrapper.
// PARAMETERS
//  IR_WIDTH     5     TAP instruction register width
//  ABITS        7     DMI address width
//  IR_DTMCS     'h10  IR code selecting DTMCS
//  IR_DMI       'h11  IR code selecting DMI
//  IDLE_HINT    3'd1  value reported in dtmcs.idle
// PORTS
//  TCLK           in   1          JTAG clock; all state updates on posedge
//  TRSTn          in   1          async active-low reset
//  ir             in   IR_WIDTH   current TAP instruction
//  dr_capture     in   1          TAP in Capture-DR
//  dr_shift       in   1          TAP in Shift-DR
//  dr_update      in   1          TAP in Update-DR
//  TDI            in   1          serial data in
//  dr_tdo         out  1          serial data out = shift_reg[0], combinational
//  dmi_req_valid  out  1          request valid
//  dmi_req_ready  in   1          DM accepts request
//  dmi_req_addr   out  ABITS      request address
//  dmi_req_data   out  32         write data
//  dmi_req_op     out  2          1=read, 2=write
//  dmi_rsp_valid  in   1          response valid
//  dmi_rsp_ready  out  1          controller accepts response
//  dmi_rsp_data   in   32         read data
//  dmi_rsp_op     in   2          0=ok, 2=failed
// BEHAVIOUR
//  Reset: dr_tdo=0, dmi_req_valid=0, dmi_rsp_ready=0, req addr/data/op=0, sticky=0, rsp_data=0, state=IDLE.
//  Shift register sr is ABITS+34 bits wide; selected length L = 32 for DTMCS, ABITS+34 for DMI, 1 otherwise.
//  Shift-DR: sr <= sr>>1 with TDI inserted at bit L-1. dr_tdo=sr[0] whenever dr_shift=1, else 0.
//  Capture DTMCS: sr[31:0] = {14'b0, 1'b0 /*hardreset*/, 1'b0 /*dmireset*/, 1'b0, IDLE_HINT, sticky[1:0], ABITS[5:0], 4'd1}.
//  Capture DMI: busy -> {req_addr, 32'h0, 2'd3} and sticky<=3 if sticky==0; else {req_addr, rsp_data, sticky}.
//  Update DTMCS: bit16 clears sticky. Bit17 (hardreset) forces IDLE, drops req_valid/rsp_ready, clears sticky.
//  Update DMI: sticky!=0 -> ignore. busy -> sticky<=3, ignore. op in {1,2} -> latch addr/data/op, go REQ. op 0/3 -> no-op.
//  FSM IDLE: busy=0.
//  FSM REQ: req_valid=1, fields stable; req_valid&req_ready -> WAIT.
//  FSM WAIT: rsp_ready=1; rsp_valid -> rsp_data<=dmi_rsp_data, sticky<=2 if rsp_op==2 and sticky==0, go IDLE.
//  busy = state!=IDLE. Minimum request latency: valid asserted the cycle after Update-DR.
//  Handshakes: valid never drops without ready, except on hardreset. A response arriving in IDLE is dropped (rsp_ready=0).
//  Simultaneous rsp_valid and Capture-DMI: capture sees busy=1 (op=3); the response is still recorded.
//  Sticky priority: the first error (3 or 2) holds until cleared; later errors do not overwrite it.
//  TRSTn mid-transaction: immediate return to reset values; the DM wrapper must tolerate an abandoned request.
// STRUCTURE
//  Package jtag_dtm_pkg: op enum (NOP/RD/WR/BUSY), rsp status enum (OK/FAIL/BUSY), IR codes, DTMCS field offsets,
//  dtm_state_e {IDLE,REQ,WAIT}.
//  Single module. The serial shift register may be split into sub-module jtag_dr_shifter (variable-length L).
// TESTING
//  1. DTMCS read after reset -> 32'h0000_1071 with ABITS=7, IDLE_HINT=1 (dmistat=0).
//  2. DMI write addr 0x10 data 0x8000_0001 op 2 -> one req_valid cycle once ready=1 (fields exact); rsp op 0 -> next DMI capture op=0.
//  3. DMI read addr 0x04 with rsp_data 0xDEAD_BEEF -> next DMI scan shifts out {0x04, 0xDEADBEEF, 0}.
//  4. Hold req_ready=0 and rescan DMI -> capture op=3, sticky=3. Later updates are ignored. Writing dtmcs bit16 -> sticky=0.
//  5. rsp_op=2 -> sticky=2; DTMCS dmistat=2. A subsequent busy does not overwrite it.
//  6. Hardreset during REQ -> req_valid low the next cycle, state IDLE. Assert TRSTn mid-WAIT -> all outputs reset immediately.

Source files
------------

// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module.
// Covers DMI op/status codes, IR codes, DTMCS field offsets and FSM states.
package jtag_dtm_pkg;

    typedef enum logic [1:0] {
        DMI_NOP  = 2'd0,
        DMI_RD   = 2'd1,
        DMI_WR   = 2'd2,
        DMI_BUSY = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        RSP_OK   = 2'd0,
        RSP_FAIL = 2'd2,
        RSP_BUSY = 2'd3
    } dmi_rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } dtm_state_e;

    localparam logic [7:0] IR_CODE_DTMCS = 8'h10;
    localparam logic [7:0] IR_CODE_DMI   = 8'h11;

    localparam int unsigned DTMCS_VERSION   = 0;
    localparam int unsigned DTMCS_ABITS     = 4;
    localparam int unsigned DTMCS_DMISTAT   = 10;
    localparam int unsigned DTMCS_IDLE      = 12;
    localparam int unsigned DTMCS_DMIRESET  = 16;
    localparam int unsigned DTMCS_HARDRESET = 17;

    localparam int unsigned DMI_DATA_LSB = 2;
    localparam int unsigned DMI_ADDR_LSB = 34;

endpackage

// File: rtl/jtag_dr_shifter.sv
// Variable-length JTAG data register: parallel capture, serial shift with
// TDI entering at bit len-1 so short registers stay LSB-aligned.
module jtag_dr_shifter #(
    parameter int unsigned W  = 41,
    parameter int unsigned LW = $clog2(W + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          capture_i,
    input  logic          shift_i,
    input  logic          tdi_i,
    input  logic [LW-1:0] len_i,
    input  logic [W-1:0]  cap_data_i,
    output logic [W-1:0]  sr_o
);

    logic [W-1:0]  sr_q, sr_d;
    logic [LW-1:0] msb;

    assign msb  = len_i - LW'(1);
    assign sr_o = sr_q;

    always_comb begin
        sr_d = sr_q;
        if (capture_i) begin
            sr_d = cap_data_i;
        end else if (shift_i) begin
            sr_d      = sr_q >> 1;
            sr_d[msb] = tdi_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr_q <= '0;
        else         sr_q <= sr_d;
    end

endmodule

// File: rtl/jtag_dmi_ctrl.sv
// Debug transport controller: DTMCS/DMI data registers behind the TAP and
// the request/response sequencer towards the Debug Module (TCLK domain).
module jtag_dmi_ctrl
    import jtag_dtm_pkg::*;
#(
    parameter int unsigned          IR_WIDTH  = 5,
    parameter int unsigned          ABITS     = 7,
    parameter logic [IR_WIDTH-1:0]  IR_DTMCS  = IR_WIDTH'(IR_CODE_DTMCS),
    parameter logic [IR_WIDTH-1:0]  IR_DMI    = IR_WIDTH'(IR_CODE_DMI),
    parameter logic [2:0]           IDLE_HINT = 3'd1
) (
    input  logic                TCLK,
    input  logic                TRSTn,
    input  logic [IR_WIDTH-1:0] ir,
    input  logic                dr_capture,
    input  logic                dr_shift,
    input  logic                dr_update,
    input  logic                TDI,
    output logic                dr_tdo,
    output logic                dmi_req_valid,
    input  logic                dmi_req_ready,
    output logic [ABITS-1:0]    dmi_req_addr,
    output logic [31:0]         dmi_req_data,
    output logic [1:0]          dmi_req_op,
    input  logic                dmi_rsp_valid,
    output logic                dmi_rsp_ready,
    input  logic [31:0]         dmi_rsp_data,
    input  logic [1:0]          dmi_rsp_op
);

    localparam int unsigned SRW = ABITS + 34;
    localparam int unsigned LW  = $clog2(SRW + 1);
    localparam logic [5:0]  ABITS_F = 6'(ABITS);

    dtm_state_e       state_q, state_d;
    logic [1:0]       sticky_q, sticky_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       op_q, op_d;

    logic             sel_dtmcs, sel_dmi, busy;
    logic [LW-1:0]    len;
    logic [SRW-1:0]   cap_data, sr;
    logic [1:0]       upd_op;

    assign sel_dtmcs = (ir == IR_DTMCS);
    assign sel_dmi   = (ir == IR_DMI);
    assign busy      = (state_q != ST_IDLE);
    assign len       = sel_dtmcs ? LW'(32) : (sel_dmi ? LW'(SRW) : LW'(1));
    assign upd_op    = sr[1:0];

    always_comb begin
        cap_data = '0;
        if (sel_dtmcs) begin
            cap_data = SRW'({14'b0, 3'b0, IDLE_HINT, sticky_q, ABITS_F, 4'd1});
        end else if (sel_dmi) begin
            cap_data = busy ? {addr_q, 32'h0, DMI_BUSY}
                            : {addr_q, rsp_data_q, sticky_q};
        end
    end

    jtag_dr_shifter #(.W(SRW), .LW(LW)) u_shifter (
        .clk_i      (TCLK),
        .rst_ni     (TRSTn),
        .capture_i  (dr_capture),
        .shift_i    (dr_shift),
        .tdi_i      (TDI),
        .len_i      (len),
        .cap_data_i (cap_data),
        .sr_o       (sr)
    );

    always_comb begin
        state_d    = state_q;
        sticky_d   = sticky_q;
        rsp_data_d = rsp_data_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        unique case (state_q)
            ST_REQ: begin
                if (dmi_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dmi_rsp_valid) begin
                    rsp_data_d = dmi_rsp_data;
                    if (dmi_rsp_op == RSP_FAIL && sticky_q == RSP_OK)
                        sticky_d = RSP_FAIL;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        // A scan that races a live transaction is the first error seen.
        if (dr_capture && sel_dmi && busy && sticky_q == RSP_OK)
            sticky_d = RSP_BUSY;
        if (dr_update && sel_dmi && sticky_q == RSP_OK) begin
            if (busy) begin
                sticky_d = RSP_BUSY;
            end else if (upd_op == DMI_RD || upd_op == DMI_WR) begin
                addr_d  = sr[SRW-1:DMI_ADDR_LSB];
                data_d  = sr[DMI_ADDR_LSB-1:DMI_DATA_LSB];
                op_d    = upd_op;
                state_d = ST_REQ;
            end
        end
        if (dr_update && sel_dtmcs) begin
            if (sr[DTMCS_DMIRESET]) sticky_d = RSP_OK;
            if (sr[DTMCS_HARDRESET]) begin
                sticky_d = RSP_OK;
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge TCLK or negedge TRSTn) begin
        if (!TRSTn) begin
            state_q    <= ST_IDLE;
            sticky_q   <= '0;
            rsp_data_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            sticky_q   <= sticky_d;
            rsp_data_q <= rsp_data_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
        end
    end

    assign dr_tdo        = dr_shift & sr[0];
    assign dmi_req_valid = (state_q == ST_REQ);
    assign dmi_rsp_ready = (state_q == ST_WAIT);
    assign dmi_req_addr  = addr_q;
    assign dmi_req_data  = data_q;
    assign dmi_req_op    = op_q;

endmodule

// File: tb/tb_jtag_dmi_ctrl.sv
// Directed bench for jtag_dmi_ctrl: transaction-level model checked every
// cycle, plus literal expectations on scanned-out registers.
module tb_jtag_dmi_ctrl;

    logic        TCLK = 1'b0;
    logic        TRSTn = 1'b0;
    logic [4:0]  ir = 5'h0;
    logic        dr_capture = 1'b0, dr_shift = 1'b0, dr_update = 1'b0;
    logic        TDI = 1'b0;
    logic        dr_tdo;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_valid = 1'b0;
    logic        dmi_rsp_ready;
    logic [31:0] dmi_rsp_data = 32'h0;
    logic [1:0]  dmi_rsp_op = 2'd0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 TCLK = ~TCLK;

    jtag_dmi_ctrl dut (
        .TCLK          (TCLK),
        .TRSTn         (TRSTn),
        .ir            (ir),
        .dr_capture    (dr_capture),
        .dr_shift      (dr_shift),
        .dr_update     (dr_update),
        .TDI           (TDI),
        .dr_tdo        (dr_tdo),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_data  (dmi_req_data),
        .dmi_req_op    (dmi_req_op),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_ready (dmi_rsp_ready),
        .dmi_rsp_data  (dmi_rsp_data),
        .dmi_rsp_op    (dmi_rsp_op)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit        m_req = 0, m_wait = 0;
    bit [1:0]  m_sticky = 0, m_op = 0;
    bit [6:0]  m_addr = 0;
    bit [31:0] m_data = 0, m_rsp = 0;
    bit        q[$];
    bit        t_busy;
    bit [1:0]  t_st;
    bit [63:0] t_cap, t_upd;
    int        t_len;

    always @(negedge TRSTn) begin
        m_req = 0; m_wait = 0; m_sticky = 0; m_op = 0;
        m_addr = 0; m_data = 0; m_rsp = 0;
        q.delete();
    end

    always @(posedge TCLK) begin
        if (TRSTn) begin
            t_busy = m_req || m_wait;
            t_st   = m_sticky;
            t_upd  = 0;
            if (dr_capture) begin
                t_cap = 0;
                t_len = 1;
                if (ir == 5'h10) begin
                    t_len = 32;
                    t_cap[31:0] = {14'b0, 3'b0, 3'd1, t_st, 6'd7, 4'd1};
                end else if (ir == 5'h11) begin
                    t_len = 41;
                    if (t_busy) begin
                        t_cap[40:0] = {m_addr, 32'h0, 2'd3};
                        if (t_st == 0) m_sticky = 3;
                    end else begin
                        t_cap[40:0] = {m_addr, m_rsp, t_st};
                    end
                end
                q.delete();
                for (int i = 0; i < t_len; i++) q.push_back(t_cap[i]);
            end else if (dr_shift && q.size() > 0) begin
                void'(q.pop_front());
                q.push_back(TDI);
            end
            if (m_req && dmi_req_ready) begin
                m_req = 0; m_wait = 1;
            end else if (m_wait && dmi_rsp_valid) begin
                m_rsp = dmi_rsp_data;
                if (dmi_rsp_op == 2 && m_sticky == 0) m_sticky = 2;
                m_wait = 0;
            end
            if (dr_update) begin
                for (int i = 0; i < q.size(); i++) t_upd[i] = q[i];
                if (ir == 5'h11 && t_st == 0) begin
                    if (t_busy) m_sticky = 3;
                    else if (t_upd[1:0] == 1 || t_upd[1:0] == 2) begin
                        m_addr = t_upd[40:34];
                        m_data = t_upd[33:2];
                        m_op   = t_upd[1:0];
                        m_req  = 1;
                    end
                end else if (ir == 5'h10) begin
                    if (t_upd[16]) m_sticky = 0;
                    if (t_upd[17]) begin
                        m_sticky = 0; m_req = 0; m_wait = 0;
                    end
                end
            end
        end
    end

    always @(negedge TCLK) begin
        chk("req_valid", dmi_req_valid, m_req);
        chk("rsp_ready", dmi_rsp_ready, m_wait);
        chk("req_addr", dmi_req_addr, m_addr);
        chk("req_data", dmi_req_data, m_data);
        chk("req_op", dmi_req_op, m_op);
        chk("tdo", dr_tdo, (dr_shift && q.size() > 0) ? q[0] : 1'b0);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge TCLK);
        #2;
    endtask

    task automatic scan(input logic [4:0] irv, input int len,
                        input logic [63:0] din, output logic [63:0] dout);
        dout = 0;
        ir = irv;
        dr_capture = 1;
        step();
        dr_capture = 0;
        dr_shift = 1;
        for (int i = 0; i < len; i++) begin
            TDI = din[i];
            #1;
            dout[i] = dr_tdo;
            step();
        end
        dr_shift = 0;
        TDI = 0;
        dr_update = 1;
        step();
        dr_update = 0;
    endtask

    task automatic accept();
        dmi_req_ready = 1;
        step();
        dmi_req_ready = 0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] op);
        dmi_rsp_valid = 1;
        dmi_rsp_data = d;
        dmi_rsp_op = op;
        step();
        dmi_rsp_valid = 0;
    endtask

    logic [63:0] d;

    initial begin
        repeat (2) step();
        chk("rst_valid", dmi_req_valid, 1'b0);
        chk("rst_rspready", dmi_rsp_ready, 1'b0);
        chk("rst_tdo", dr_tdo, 1'b0);
        chk("rst_addr", dmi_req_addr, 7'h0);
        TRSTn = 1;
        step();

        scan(5'h10, 32, 0, d);
        chk("dtmcs_reset", d[31:0], 32'h0000_1071);

        scan(5'h11, 41, {7'h10, 32'h8000_0001, 2'd2}, d);
        chk("wr_valid", dmi_req_valid, 1'b1);
        chk("wr_addr", dmi_req_addr, 7'h10);
        chk("wr_data", dmi_req_data, 32'h8000_0001);
        chk("wr_op", dmi_req_op, 2'd2);
        repeat (2) step();
        chk("wr_hold", dmi_req_valid, 1'b1);
        accept();
        chk("wr_one_cycle", dmi_req_valid, 1'b0);
        respond(32'h0, 2'd0);
        scan(5'h11, 41, 0, d);
        chk("wr_status", d[1:0], 2'd0);

        scan(5'h11, 41, {7'h04, 32'h0, 2'd1}, d);
        accept();
        respond(32'hDEAD_BEEF, 2'd0);
        scan(5'h11, 41, 0, d);
        chk("rd_scan", d[40:0], {7'h04, 32'hDEAD_BEEF, 2'd0});

        scan(5'h11, 41, {7'h05, 32'h0, 2'd1}, d);
        scan(5'h11, 41, 0, d);
        chk("busy_op", d[1:0], 2'd3);
        chk("busy_addr", d[40:34], 7'h05);
        scan(5'h10, 32, 0, d);
        chk("busy_dmistat", d[31:0], 32'h0000_1C71);
        scan(5'h11, 41, {7'h0A, 32'h55, 2'd2}, d);
        chk("busy_ignored", dmi_req_addr, 7'h05);
        scan(5'h10, 32, 32'h0001_0000, d);
        scan(5'h10, 32, 0, d);
        chk("dmireset", d[31:0], 32'h0000_1071);
        accept();
        respond(32'h0, 2'd0);

        scan(5'h11, 41, {7'h06, 32'h0, 2'd1}, d);
        accept();
        respond(32'h0000_0BAD, 2'd2);
        scan(5'h10, 32, 0, d);
        chk("fail_dmistat", d[31:0], 32'h0000_1871);
        scan(5'h11, 41, {7'h0B, 32'h1, 2'd2}, d);
        chk("fail_op", d[1:0], 2'd2);
        chk("fail_ignored", dmi_req_valid, 1'b0);
        scan(5'h11, 41, 0, d);
        chk("fail_kept", d[1:0], 2'd2);
        scan(5'h10, 32, 32'h0001_0000, d);

        scan(5'h11, 41, {7'h07, 32'h0, 2'd1}, d);
        accept();
        dmi_rsp_valid = 1;
        dmi_rsp_data = 32'h1234_5678;
        dmi_rsp_op = 2'd0;
        scan(5'h11, 41, 0, d);
        dmi_rsp_valid = 0;
        chk("race_op", d[1:0], 2'd3);
        scan(5'h10, 32, 32'h0001_0000, d);
        scan(5'h11, 41, 0, d);
        chk("race_rsp", d[40:0], {7'h07, 32'h1234_5678, 2'd0});

        scan(5'h11, 41, {7'h08, 32'hCAFE, 2'd2}, d);
        chk("hr_pre", dmi_req_valid, 1'b1);
        scan(5'h10, 32, 32'h0002_0000, d);
        chk("hr_valid", dmi_req_valid, 1'b0);
        scan(5'h10, 32, 0, d);
        chk("hr_dtmcs", d[31:0], 32'h0000_1071);

        scan(5'h11, 41, {7'h09, 32'h0, 2'd1}, d);
        accept();
        chk("wait_rspready", dmi_rsp_ready, 1'b1);
        #1;
        TRSTn = 0;
        #1;
        chk("trst_rspready", dmi_rsp_ready, 1'b0);
        chk("trst_valid", dmi_req_valid, 1'b0);
        chk("trst_addr", dmi_req_addr, 7'h0);
        chk("trst_op", dmi_req_op, 2'd0);
        step();
        TRSTn = 1;
        step();
        scan(5'h10, 32, 0, d);
        chk("post_trst", d[31:0], 32'h0000_1071);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
